execute: RTL and testbench

Execute stage of the JARVIS RV32 pipeline, sitting directly upstream of the memory-access stage and feeding its inputs through a registered boundary.
- Computes the ALU result, `pc + 4`, and passes through the destination, result-select and store controls.
- Single-cycle ops (RV32I ALU set plus MUL) retire one cycle after acceptance.
- DIV/DIVU/REM/REMU use an iterative 32-step divider and stall upstream via `busy` until done.

---
 rtl/exec_pkg.sv | 44 ++++
 rtl/execute_if.sv | 47 ++++
 rtl/execute_div_iter.sv | 71 +++++++
 rtl/execute.sv | 194 +++++++++++++++++++
 tb/tb_execute.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the JARVIS RV32 execute stage: ALU op codes,
// execute FSM states, divider step count and op-classification helpers.
package exec_pkg;

    localparam int DIV_STEPS = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_DIVU = 4'd12,
        ALU_REM  = 4'd13,
        ALU_REMU = 4'd14
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } exec_state_t;

    function automatic logic is_div_op(alu_op_t op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_signed_div(alu_op_t op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    // Quotient-producing divide ops; the rest of the divide group returns the remainder.
    function automatic logic is_quot_op(alu_op_t op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/execute_if.sv
// Decode-to-execute-to-memacc bundle: instruction inputs from decode and the
// registered results handed on to the memory-access stage.
interface execute_if #(
    parameter int XLEN = 32
);
    import exec_pkg::*;

    logic             valid_in;
    logic [3:0]       alu_op_in;
    logic [XLEN-1:0]  src_a_in;
    logic [XLEN-1:0]  src_b_in;
    logic [XLEN-1:0]  pc_in;
    logic             rd_write_enable_in;
    logic             res_src_in;
    logic             mem_write_enable_in;
    logic [4:0]       rd_write_addr_in;
    logic [XLEN-1:0]  mem_write_data_in;

    logic             busy;
    logic             valid_out;
    logic [XLEN-1:0]  exec_data_out;
    logic [XLEN-1:0]  next_pc_out;
    logic [XLEN-1:0]  mem_write_data_out;
    logic             rd_write_enable_out;
    logic             res_src_out;
    logic             mem_write_enable_out;
    logic [4:0]       rd_write_addr_out;

    modport master (
        output valid_in, alu_op_in, src_a_in, src_b_in, pc_in,
               rd_write_enable_in, res_src_in, mem_write_enable_in,
               rd_write_addr_in, mem_write_data_in,
        input  busy, valid_out, exec_data_out, next_pc_out, mem_write_data_out,
               rd_write_enable_out, res_src_out, mem_write_enable_out,
               rd_write_addr_out
    );

    modport slave (
        input  valid_in, alu_op_in, src_a_in, src_b_in, pc_in,
               rd_write_enable_in, res_src_in, mem_write_enable_in,
               rd_write_addr_in, mem_write_data_in,
        output busy, valid_out, exec_data_out, next_pc_out, mem_write_data_out,
               rd_write_enable_out, res_src_out, mem_write_enable_out,
               rd_write_addr_out
    );

endinterface

// File: rtl/execute_div_iter.sv
// Iterative restoring divider working on operand magnitudes; one quotient bit
// per cycle. Sign fix-up of the results is left to the caller.
module div_iter #(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    import exec_pkg::*;

    localparam int CW = $clog2(DIV_STEPS);

    logic            running;
    logic [CW-1:0]   step_cnt;
    logic [XLEN-1:0] part_rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvsr;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] trial;
    logic            take;

    assign abs_a = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
    assign abs_b = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;

    // The dividend is shifted out of quo's top while quotient bits enter at the bottom.
    always_comb begin
        shifted = {part_rem, quo[XLEN-1]};
        take    = (shifted >= {1'b0, dvsr});
        trial   = shifted[XLEN-1:0] - dvsr;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            running  <= 1'b0;
            step_cnt <= '0;
            part_rem <= '0;
            quo      <= '0;
            dvsr     <= '0;
        end else if (start && !running) begin
            running  <= 1'b1;
            step_cnt <= '0;
            part_rem <= '0;
            quo      <= abs_a;
            dvsr     <= abs_b;
        end else if (running) begin
            part_rem <= take ? trial : shifted[XLEN-1:0];
            quo      <= {quo[XLEN-2:0], take};
            step_cnt <= step_cnt + CW'(1);
            if (step_cnt == CW'(DIV_STEPS - 1)) begin
                running <= 1'b0;
            end
        end
    end

    assign busy      = running;
    assign done      = running && (step_cnt == CW'(DIV_STEPS - 1));
    assign quotient  = quo;
    assign remainder = part_rem;

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle ALU and MUL, divide special cases, iterative
// divide sequencing, and the registered boundary into memacc.
module execute #(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = exec_pkg::DIV_STEPS
) (
    input  logic      clk,
    input  logic      reset_n,
    execute_if.slave  bus
);
    import exec_pkg::*;

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    alu_op_t         op;
    exec_state_t     state, state_next;
    logic [XLEN-1:0] a, b, next_pc;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_result, special_result, single_result, div_result;
    logic            div_special;
    logic            load_single, load_div, div_start;
    logic            div_busy, div_done;
    logic [XLEN-1:0] div_quo, div_rem;

    alu_op_t         lat_op;
    logic            lat_q_neg, lat_r_neg;
    logic            lat_rd_we, lat_res_src, lat_mem_we;
    logic [4:0]      lat_rd_addr;
    logic [XLEN-1:0] lat_mem_wdata, lat_next_pc;

    assign op      = alu_op_t'(bus.alu_op_in);
    assign a       = bus.src_a_in;
    assign b       = bus.src_b_in;
    assign shamt   = b[SHW-1:0];
    assign next_pc = bus.pc_in + XLEN'(4);

    always_comb begin
        alu_result = '0;
        case (op)
            ALU_ADD:  alu_result = a + b;
            ALU_SUB:  alu_result = a - b;
            ALU_AND:  alu_result = a & b;
            ALU_OR:   alu_result = a | b;
            ALU_XOR:  alu_result = a ^ b;
            ALU_SLL:  alu_result = a << shamt;
            ALU_SRL:  alu_result = a >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_MUL:  alu_result = a * b;
            default:  alu_result = '0;
        endcase
    end

    // Divide-by-zero and signed overflow resolve in one cycle, bypassing the divider.
    always_comb begin
        div_special    = 1'b0;
        special_result = '0;
        if (b == '0) begin
            div_special    = 1'b1;
            special_result = is_quot_op(op) ? '1 : a;
        end else if (is_signed_div(op) && (a == MIN_INT) && (b == '1)) begin
            div_special    = 1'b1;
            special_result = is_quot_op(op) ? MIN_INT : '0;
        end
    end

    assign single_result = is_div_op(op) ? special_result : alu_result;

    always_comb begin
        if (is_quot_op(lat_op)) begin
            div_result = lat_q_neg ? -div_quo : div_quo;
        end else begin
            div_result = lat_r_neg ? -div_rem : div_rem;
        end
    end

    div_iter #(
        .XLEN      (XLEN),
        .DIV_STEPS (DIV_STEPS)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .is_signed (is_signed_div(op)),
        .dividend  (a),
        .divisor   (b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_single = 1'b0;
        load_div    = 1'b0;
        div_start   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    if (is_div_op(op) && !div_special) begin
                        div_start  = 1'b1;
                        state_next = ST_DIV;
                    end else begin
                        load_single = 1'b1;
                    end
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                load_div   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.busy = (state != ST_IDLE) || div_busy;

    // Controls are captured at divide acceptance so the result never depends on decode holding.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lat_op        <= ALU_ADD;
            lat_q_neg     <= 1'b0;
            lat_r_neg     <= 1'b0;
            lat_rd_we     <= 1'b0;
            lat_res_src   <= 1'b0;
            lat_mem_we    <= 1'b0;
            lat_rd_addr   <= '0;
            lat_mem_wdata <= '0;
            lat_next_pc   <= '0;
        end else if (div_start) begin
            lat_op        <= op;
            lat_q_neg     <= is_signed_div(op) && (a[XLEN-1] ^ b[XLEN-1]);
            lat_r_neg     <= is_signed_div(op) && a[XLEN-1];
            lat_rd_we     <= bus.rd_write_enable_in;
            lat_res_src   <= bus.res_src_in;
            lat_mem_we    <= bus.mem_write_enable_in;
            lat_rd_addr   <= bus.rd_write_addr_in;
            lat_mem_wdata <= bus.mem_write_data_in;
            lat_next_pc   <= next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.valid_out            <= 1'b0;
            bus.exec_data_out        <= '0;
            bus.next_pc_out          <= '0;
            bus.mem_write_data_out   <= '0;
            bus.rd_write_enable_out  <= 1'b0;
            bus.res_src_out          <= 1'b0;
            bus.mem_write_enable_out <= 1'b0;
            bus.rd_write_addr_out    <= '0;
        end else if (load_single) begin
            bus.valid_out            <= 1'b1;
            bus.exec_data_out        <= single_result;
            bus.next_pc_out          <= next_pc;
            bus.mem_write_data_out   <= bus.mem_write_data_in;
            bus.rd_write_enable_out  <= bus.rd_write_enable_in;
            bus.res_src_out          <= bus.res_src_in;
            bus.mem_write_enable_out <= bus.mem_write_enable_in;
            bus.rd_write_addr_out    <= bus.rd_write_addr_in;
        end else if (load_div) begin
            bus.valid_out            <= 1'b1;
            bus.exec_data_out        <= div_result;
            bus.next_pc_out          <= lat_next_pc;
            bus.mem_write_data_out   <= lat_mem_wdata;
            bus.rd_write_enable_out  <= lat_rd_we;
            bus.res_src_out          <= lat_res_src;
            bus.mem_write_enable_out <= lat_mem_we;
            bus.rd_write_addr_out    <= lat_rd_addr;
        end else begin
            bus.valid_out            <= 1'b0;
            bus.rd_write_enable_out  <= 1'b0;
            bus.mem_write_enable_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Directed-vector bench for the execute stage: ALU ops, iterative divide
// timing, divide special cases, store bubbles and reset during a divide.
module tb_execute;
    import exec_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    execute_if #(.XLEN(32)) bus ();

    execute #(
        .XLEN      (32),
        .DIV_STEPS (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [4:0] rd);
        bus.valid_in            = 1'b1;
        bus.alu_op_in           = op;
        bus.src_a_in            = a;
        bus.src_b_in            = b;
        bus.pc_in               = pc;
        bus.rd_write_enable_in  = 1'b1;
        bus.rd_write_addr_in    = rd;
        bus.res_src_in          = 1'b0;
        bus.mem_write_enable_in = 1'b0;
        bus.mem_write_data_in   = 32'h0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_op(ALU_ADD, 32'h1, 32'h2, 32'h40, 5'd3);
        tick();
        tick();
        vectors++;
        if ({bus.valid_out, bus.busy} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_valid_busy: got %b expected 00", {bus.valid_out, bus.busy});
        end
        vectors++;
        if ({bus.exec_data_out, bus.next_pc_out, bus.mem_write_data_out} !== 96'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h %h %h expected all 0",
                     bus.exec_data_out, bus.next_pc_out, bus.mem_write_data_out);
        end
        vectors++;
        if ({bus.rd_write_enable_out, bus.res_src_out, bus.mem_write_enable_out,
             bus.rd_write_addr_out} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0", {bus.rd_write_enable_out,
                     bus.res_src_out, bus.mem_write_enable_out, bus.rd_write_addr_out});
        end
        reset_n      = 1'b1;
        bus.valid_in = 1'b0;
        tick();
    endtask

    task automatic test_add();
        drive_op(ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'hFFFFFFFC, 5'd5);
        tick();
        bus.valid_in = 1'b0;
        vectors++;
        if (bus.exec_data_out !== 32'h80000000 || bus.valid_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL add_overflow: got %h valid %b expected 80000000 valid 1",
                     bus.exec_data_out, bus.valid_out);
        end
        vectors++;
        if (bus.next_pc_out !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL add_pc_wrap: got %h expected 00000000", bus.next_pc_out);
        end
        vectors++;
        if (bus.rd_write_addr_out !== 5'd5 || bus.rd_write_enable_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL add_rd: got %0d we %b expected 5 we 1",
                     bus.rd_write_addr_out, bus.rd_write_enable_out);
        end
        tick();
    endtask

    task automatic test_back_to_back_alu();
        alu_op_t     ops [10] = '{ALU_SRA, ALU_SLTU, ALU_SLT, ALU_SUB, ALU_XOR,
                                  ALU_SLL, ALU_SRL, ALU_MUL, ALU_OR, ALU_AND};
        logic [31:0] as  [10] = '{32'h80000000, 32'h1, 32'h1, 32'h0, 32'hF0F0F0F0,
                                  32'h1, 32'h80000000, 32'h12345678, 32'h0000000F, 32'hFFFF0000};
        logic [31:0] bs  [10] = '{32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFF00FF00,
                                  32'h3F, 32'h21, 32'h10, 32'h000000F0, 32'h0F0F0F0F};
        logic [31:0] exp [10] = '{32'hF8000000, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h0FF00FF0,
                                  32'h80000000, 32'h40000000, 32'h23456780, 32'h000000FF, 32'h0F0F0000};
        for (int i = 0; i < 10; i++) begin
            drive_op(ops[i], as[i], bs[i], 32'h1000 + 32'(4 * i), 5'(i + 1));
            tick();
            vectors++;
            if (bus.valid_out !== 1'b1 || bus.exec_data_out !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL alu_op%0d: got %h valid %b expected %h valid 1",
                         i, bus.exec_data_out, bus.valid_out, exp[i]);
            end
            vectors++;
            if (bus.next_pc_out !== 32'h1004 + 32'(4 * i)) begin
                miscompares++;
                $display("[TB] FAIL alu_pc%0d: got %h expected %h",
                         i, bus.next_pc_out, 32'h1004 + 32'(4 * i));
            end
        end
        bus.valid_in = 1'b0;
        tick();
    endtask

    task automatic test_divide();
        alu_op_t     ops [3] = '{ALU_DIV, ALU_REM, ALU_DIVU};
        logic [31:0] as  [3] = '{32'hFFFFFF9C, 32'hFFFFFF9C, 32'h00000064};
        logic [31:0] exp [3] = '{32'hFFFFFFF2, 32'hFFFFFFFE, 32'h0000000E};
        int n;
        int bad;
        for (int i = 0; i < 3; i++) begin
            drive_op(ops[i], as[i], 32'h7, 32'h200, 5'(9 + i));
            tick();
            n   = 0;
            bad = 0;
            while (bus.busy === 1'b1 && n < 40) begin
                n++;
                if (bus.valid_out !== 1'b0 || bus.rd_write_enable_out !== 1'b0) bad++;
                tick();
            end
            bus.valid_in = 1'b0;
            vectors++;
            if (n !== 33) begin
                miscompares++;
                $display("[TB] FAIL div%0d_busy_cycles: got %0d expected 33", i, n);
            end
            vectors++;
            if (bad !== 0) begin
                miscompares++;
                $display("[TB] FAIL div%0d_bubble_while_busy: got %0d bad cycles expected 0", i, bad);
            end
            vectors++;
            if (bus.valid_out !== 1'b1 || bus.exec_data_out !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL div%0d_result: got %h valid %b expected %h valid 1",
                         i, bus.exec_data_out, bus.valid_out, exp[i]);
            end
            vectors++;
            if (bus.rd_write_addr_out !== 5'(9 + i) || bus.next_pc_out !== 32'h204) begin
                miscompares++;
                $display("[TB] FAIL div%0d_ctrl: got rd %0d pc %h expected rd %0d pc 00000204",
                         i, bus.rd_write_addr_out, bus.next_pc_out, 9 + i);
            end
            tick();
            vectors++;
            if (bus.valid_out !== 1'b0 || bus.exec_data_out !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL div%0d_after: got %h valid %b expected %h valid 0",
                         i, bus.exec_data_out, bus.valid_out, exp[i]);
            end
        end
    endtask

    task automatic test_div_special();
        alu_op_t     ops [5] = '{ALU_DIVU, ALU_REMU, ALU_DIV, ALU_REM, ALU_REM};
        logic [31:0] as  [5] = '{32'h1234, 32'h1234, 32'h80000000, 32'h80000000, 32'hFFFFFF9C};
        logic [31:0] bs  [5] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0, 32'hFFFFFF9C};
        for (int i = 0; i < 5; i++) begin
            drive_op(ops[i], as[i], bs[i], 32'h300, 5'd7);
            tick();
            vectors++;
            if (bus.busy !== 1'b0 || bus.valid_out !== 1'b1 || bus.exec_data_out !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL div_special%0d: got %h valid %b busy %b expected %h valid 1 busy 0",
                         i, bus.exec_data_out, bus.valid_out, bus.busy, exp[i]);
            end
        end
        bus.valid_in = 1'b0;
        tick();
    endtask

    task automatic test_store_bubble();
        drive_op(ALU_ADD, 32'h100, 32'h8, 32'h400, 5'd0);
        bus.rd_write_enable_in  = 1'b0;
        bus.mem_write_enable_in = 1'b1;
        bus.mem_write_data_in   = 32'hABCDABCD;
        tick();
        bus.valid_in          = 1'b0;
        bus.mem_write_data_in = 32'h0;
        bus.src_a_in          = 32'h5555;
        vectors++;
        if (bus.mem_write_enable_out !== 1'b1 || bus.mem_write_data_out !== 32'hABCDABCD ||
            bus.exec_data_out !== 32'h108) begin
            miscompares++;
            $display("[TB] FAIL store_valid: got we %b data %h addr %h expected we 1 data abcdabcd addr 108",
                     bus.mem_write_enable_out, bus.mem_write_data_out, bus.exec_data_out);
        end
        tick();
        vectors++;
        if (bus.valid_out !== 1'b0 || bus.mem_write_enable_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL store_bubble_we: got valid %b we %b expected 0 0",
                     bus.valid_out, bus.mem_write_enable_out);
        end
        vectors++;
        if (bus.mem_write_data_out !== 32'hABCDABCD || bus.exec_data_out !== 32'h108) begin
            miscompares++;
            $display("[TB] FAIL store_bubble_hold: got %h %h expected abcdabcd 00000108",
                     bus.mem_write_data_out, bus.exec_data_out);
        end
    endtask

    task automatic test_reset_mid_div();
        int seen;
        drive_op(ALU_DIV, 32'hFFFFFF9C, 32'h7, 32'h500, 5'd12);
        tick();
        repeat (9) tick();
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL middiv_busy: got %b expected 1", bus.busy);
        end
        reset_n = 1'b0;
        tick();
        vectors++;
        if ({bus.busy, bus.valid_out, bus.rd_write_enable_out, bus.res_src_out,
             bus.mem_write_enable_out, bus.rd_write_addr_out} !== 10'h0) begin
            miscompares++;
            $display("[TB] FAIL middiv_reset_ctrl: got busy %b valid %b rd %0d expected all 0",
                     bus.busy, bus.valid_out, bus.rd_write_addr_out);
        end
        vectors++;
        if ({bus.exec_data_out, bus.next_pc_out, bus.mem_write_data_out} !== 96'h0) begin
            miscompares++;
            $display("[TB] FAIL middiv_reset_data: got %h %h %h expected all 0",
                     bus.exec_data_out, bus.next_pc_out, bus.mem_write_data_out);
        end
        reset_n = 1'b1;
        drive_op(ALU_ADD, 32'h2, 32'h3, 32'h10, 5'd4);
        tick();
        bus.valid_in = 1'b0;
        vectors++;
        if (bus.valid_out !== 1'b1 || bus.exec_data_out !== 32'h5 || bus.next_pc_out !== 32'h14 ||
            bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_add: got %h pc %h valid %b busy %b expected 5 pc 14 valid 1 busy 0",
                     bus.exec_data_out, bus.next_pc_out, bus.valid_out, bus.busy);
        end
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("[TB] FAIL aborted_div_quiet: got %0d active cycles expected 0", seen);
        end
    endtask

    initial begin
        reset_n                 = 1'b0;
        bus.valid_in            = 1'b0;
        bus.alu_op_in           = 4'd0;
        bus.src_a_in            = 32'h0;
        bus.src_b_in            = 32'h0;
        bus.pc_in               = 32'h0;
        bus.rd_write_enable_in  = 1'b0;
        bus.res_src_in          = 1'b0;
        bus.mem_write_enable_in = 1'b0;
        bus.rd_write_addr_in    = 5'd0;
        bus.mem_write_data_in   = 32'h0;
        $display("[TB] starting execute stage bench");
        test_reset();
        test_add();
        test_back_to_back_alu();
        test_divide();
        test_div_special();
        test_store_bubble();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
